// File: rtl/rr_grant_data_mux.sv
// Grant-driven data capture: accepts one word per cycle from the granted master,
// tags it with its source index, buffers it in a FIFO and keeps per-master counts.
module rr_grant_data_mux #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 GNT,
    input  logic [4*W-1:0]             DIN,
    input  logic [3:0]                 DVALID,
    output logic [3:0]                 DREADY,
    output logic [W-1:0]               DOUT,
    output logic [1:0]                 DOUT_SRC,
    output logic                       DOUT_VALID,
    input  logic                       DOUT_READY,
    output logic [$clog2(DEPTH):0]     LEVEL,
    input  logic                       CNT_CLR,
    output logic [4*16-1:0]            CNT,
    output logic                       GNT_ERR
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = W + 2;

    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [W-1:0]  dout_q, dout_d;
    logic [1:0]    src_q, src_d;
    logic          valid_q, valid_d;
    logic [15:0]   cnt_q [4];
    logic [15:0]   cnt_d [4];
    logic          err_q, err_d;

    logic          onehot, multihot, full, push, pop;
    logic [1:0]    gnt_idx;
    int unsigned   base;
    logic [EW-1:0] push_word, head;

    always_comb begin
        onehot   = (GNT != 4'd0) && ((GNT & (GNT - 4'd1)) == 4'd0);
        multihot = (GNT != 4'd0) && !onehot;
        full     = (level_q == LW'(DEPTH));
        DREADY   = (onehot && !full) ? GNT : 4'd0;
        push     = |(DREADY & DVALID);
        pop      = valid_q && DOUT_READY;

        gnt_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (GNT[i]) gnt_idx = 2'(i);
        end
        base      = 32'(gnt_idx) * W;
        push_word = {gnt_idx, DIN[base +: W]};

        wr_d    = wr_q + AW'(push);
        rd_d    = rd_q + AW'(pop);
        level_d = level_q + LW'(push) - LW'(pop);

        mem_d = mem_q;
        if (push) mem_d[wr_q] = push_word;

        // New head is the word being written only when it lands exactly at the next read slot
        head = (push && (rd_d == wr_q)) ? push_word : mem_q[rd_d];

        valid_d = (level_d != LW'(0));
        dout_d  = valid_d ? head[W-1:0]    : dout_q;
        src_d   = valid_d ? head[EW-1 -: 2] : src_q;

        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (CNT_CLR) begin
                cnt_d[i] = 16'd0;
            end else if (push && (gnt_idx == 2'(i)) && (cnt_q[i] != 16'hFFFF)) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
            CNT[i*16 +: 16] = cnt_q[i];
        end

        err_d = CNT_CLR ? 1'b0 : (err_q | multihot);

        DOUT       = dout_q;
        DOUT_SRC   = src_q;
        DOUT_VALID = valid_q;
        LEVEL      = level_q;
        GNT_ERR    = err_q;
    end

    // Storage needs no reset: entries are only read once written behind valid pointers
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            valid_q <= 1'b0;
            dout_q  <= '0;
            src_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= 16'd0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            valid_q <= valid_d;
            dout_q  <= dout_d;
            src_q   <= src_d;
            err_q   <= err_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

endmodule
